// File: rtl/tcp_conn_ctrl_if.sv
// Metadata-in / transmit-request bundle between the TCP header parser, tcp_conn_ctrl and the tx-header builder.
// master = parser/builder side, slave = tcp_conn_ctrl.
interface tcp_conn_ctrl_if;
    logic        meta_valid;
    logic        meta_ready;
    logic [15:0] meta_src_port;
    logic [15:0] meta_dst_port;
    logic [31:0] meta_seq_num;
    logic [31:0] meta_ack_num;
    logic [7:0]  meta_flags;
    logic [15:0] meta_window_size;
    logic [15:0] meta_payload_len;
    logic        pl_accept;
    logic        pl_drop;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_flags;
    logic [31:0] tx_seq_num;
    logic [31:0] tx_ack_num;
    logic [15:0] tx_src_port;
    logic [15:0] tx_dst_port;
    logic [15:0] tx_window;

    modport master (
        output meta_valid, meta_src_port, meta_dst_port, meta_seq_num, meta_ack_num,
               meta_flags, meta_window_size, meta_payload_len, tx_ready,
        input  meta_ready, pl_accept, pl_drop, tx_valid, tx_flags, tx_seq_num,
               tx_ack_num, tx_src_port, tx_dst_port, tx_window
    );

    modport slave (
        input  meta_valid, meta_src_port, meta_dst_port, meta_seq_num, meta_ack_num,
               meta_flags, meta_window_size, meta_payload_len, tx_ready,
        output meta_ready, pl_accept, pl_drop, tx_valid, tx_flags, tx_seq_num,
               tx_ack_num, tx_src_port, tx_dst_port, tx_window
    );
endinterface

// File: rtl/tcp_conn_ctrl.sv
// Single-connection passive-open TCP controller: per-segment accept/drop verdict and SYN-ACK/ACK/FIN-ACK scheduling.
// Optional saturating statistics counters are built when TCP_CTRL_STATS_EN is defined.
module tcp_conn_ctrl #(
    parameter logic [15:0] RX_WINDOW = 16'd1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    cfg_local_port,
    input  logic [31:0]    cfg_isn,
    tcp_conn_ctrl_if.slave bus,
    output logic [1:0]     conn_state,
    output logic [15:0]    peer_window,
    output logic [15:0]    stat_rx_segs,
    output logic [15:0]    stat_drops
);
    typedef enum logic [1:0] {
        ST_LISTEN      = 2'd0,
        ST_SYN_RCVD    = 2'd1,
        ST_ESTABLISHED = 2'd2,
        ST_LAST_ACK    = 2'd3
    } conn_state_e;

    typedef enum logic [1:0] {PH_IDLE, PH_EVAL, PH_TX} phase_e;

    localparam logic [7:0] FL_SYNACK = 8'h12;
    localparam logic [7:0] FL_ACK    = 8'h10;
    localparam logic [7:0] FL_FINACK = 8'h11;

    phase_e      r_phase;
    conn_state_e r_conn_state;
    logic [31:0] r_rcv_nxt, r_snd_nxt;
    logic [15:0] r_peer_port, r_peer_window;
    logic [15:0] r_m_src, r_m_dst, r_m_len;
    logic [31:0] r_m_seq, r_m_ack;
    logic [7:0]  r_m_flags;
    logic        r_meta_ready, r_pl_accept, r_pl_drop, r_tx_valid;
    logic [7:0]  r_tx_flags;
    logic [31:0] r_tx_seq, r_tx_ack;
    logic [15:0] r_tx_src, r_tx_dst, r_tx_window;

    logic        w_meta_hs, w_fin, w_syn, w_rst, w_ack, w_port_ok, w_len_nz, w_unused_flags;
    logic [31:0] w_rcv_data;

    assign w_meta_hs      = r_meta_ready && bus.meta_valid;
    assign w_fin          = r_m_flags[0];
    assign w_syn          = r_m_flags[1];
    assign w_rst          = r_m_flags[2];
    assign w_ack          = r_m_flags[4];
    assign w_unused_flags = ^{r_m_flags[7:5], r_m_flags[3]};
    assign w_len_nz       = (r_m_len != 16'd0);
    assign w_rcv_data     = r_rcv_nxt + {16'd0, r_m_len};
    assign w_port_ok      = (r_m_dst == cfg_local_port) &&
                            ((r_conn_state == ST_LISTEN) || (r_m_src == r_peer_port));

    logic        w_accept, w_tx_req, w_est;
    logic [7:0]  w_tx_flags;
    logic [31:0] w_tx_seq, w_tx_ack, w_rcv_nxt_n, w_snd_nxt_n;
    logic [15:0] w_peer_n;
    conn_state_e w_state_n;

    // NOTE: every signal gets a default first, so no path through the block can infer a latch.
    always_comb begin
        w_accept    = 1'b0;
        w_tx_req    = 1'b0;
        w_est       = 1'b0;
        w_tx_flags  = 8'h00;
        w_tx_seq    = 32'd0;
        w_tx_ack    = 32'd0;
        w_rcv_nxt_n = r_rcv_nxt;
        w_snd_nxt_n = r_snd_nxt;
        w_peer_n    = r_peer_port;
        w_state_n   = r_conn_state;
        if (w_port_ok) begin
            if (w_rst) begin
                w_state_n = ST_LISTEN;
            end else begin
                case (r_conn_state)
                    ST_LISTEN: if (w_syn && !w_ack) begin
                        w_peer_n    = r_m_src;
                        w_rcv_nxt_n = r_m_seq + 32'd1;
                        w_snd_nxt_n = cfg_isn + 32'd1;
                        w_state_n   = ST_SYN_RCVD;
                        w_tx_req    = 1'b1;
                        w_tx_flags  = FL_SYNACK;
                        w_tx_seq    = cfg_isn;
                        w_tx_ack    = r_m_seq + 32'd1;
                    end
                    ST_SYN_RCVD: begin
                        if (w_ack && (r_m_ack == r_snd_nxt)) begin
                            w_est = 1'b1;
                        end else if (w_syn && !w_ack && (r_m_seq + 32'd1 == r_rcv_nxt)) begin
                            w_tx_req   = 1'b1;
                            w_tx_flags = FL_SYNACK;
                            w_tx_seq   = r_snd_nxt - 32'd1;
                            w_tx_ack   = r_rcv_nxt;
                        end
                    end
                    ST_ESTABLISHED: w_est = 1'b1;
                    ST_LAST_ACK: if (w_ack && (r_m_ack == r_snd_nxt)) w_state_n = ST_LISTEN;
                endcase
                // The handshake-completing ACK may itself carry data or FIN.
                if (w_est) begin
                    w_state_n = ST_ESTABLISHED;
                    w_tx_seq  = r_snd_nxt;
                    if (r_m_seq == r_rcv_nxt) begin
                        w_accept    = w_len_nz;
                        w_rcv_nxt_n = w_rcv_data;
                        if (w_fin) begin
                            w_rcv_nxt_n = w_rcv_data + 32'd1;
                            w_snd_nxt_n = r_snd_nxt + 32'd1;
                            w_state_n   = ST_LAST_ACK;
                            w_tx_req    = 1'b1;
                            w_tx_flags  = FL_FINACK;
                            w_tx_ack    = w_rcv_data + 32'd1;
                        end else if (w_len_nz) begin
                            w_tx_req   = 1'b1;
                            w_tx_flags = FL_ACK;
                            w_tx_ack   = w_rcv_data;
                        end
                    end else begin
                        w_tx_req   = 1'b1;
                        w_tx_flags = FL_ACK;
                        w_tx_ack   = r_rcv_nxt;
                    end
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase       <= PH_IDLE;
            r_conn_state  <= ST_LISTEN;
            r_rcv_nxt     <= 32'd0;
            r_snd_nxt     <= 32'd0;
            r_peer_port   <= 16'd0;
            r_peer_window <= 16'd0;
            r_m_src       <= 16'd0;
            r_m_dst       <= 16'd0;
            r_m_len       <= 16'd0;
            r_m_seq       <= 32'd0;
            r_m_ack       <= 32'd0;
            r_m_flags     <= 8'h00;
            r_meta_ready  <= 1'b1;
            r_pl_accept   <= 1'b0;
            r_pl_drop     <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_flags    <= 8'h00;
            r_tx_seq      <= 32'd0;
            r_tx_ack      <= 32'd0;
            r_tx_src      <= 16'd0;
            r_tx_dst      <= 16'd0;
            r_tx_window   <= 16'd0;
        end else begin
            r_pl_accept <= 1'b0;
            r_pl_drop   <= 1'b0;
            case (r_phase)
                PH_IDLE: if (w_meta_hs) begin
                    r_m_src       <= bus.meta_src_port;
                    r_m_dst       <= bus.meta_dst_port;
                    r_m_seq       <= bus.meta_seq_num;
                    r_m_ack       <= bus.meta_ack_num;
                    r_m_flags     <= bus.meta_flags;
                    r_m_len       <= bus.meta_payload_len;
                    r_peer_window <= bus.meta_window_size;
                    r_meta_ready  <= 1'b0;
                    r_phase       <= PH_EVAL;
                end
                PH_EVAL: begin
                    r_pl_accept  <= w_accept;
                    r_pl_drop    <= !w_accept;
                    r_conn_state <= w_state_n;
                    r_rcv_nxt    <= w_rcv_nxt_n;
                    r_snd_nxt    <= w_snd_nxt_n;
                    r_peer_port  <= w_peer_n;
                    if (w_tx_req) begin
                        r_tx_valid  <= 1'b1;
                        r_tx_flags  <= w_tx_flags;
                        r_tx_seq    <= w_tx_seq;
                        r_tx_ack    <= w_tx_ack;
                        r_tx_src    <= cfg_local_port;
                        r_tx_dst    <= w_peer_n;
                        r_tx_window <= RX_WINDOW;
                        r_phase     <= PH_TX;
                    end else begin
                        r_meta_ready <= 1'b1;
                        r_phase      <= PH_IDLE;
                    end
                end
                PH_TX: if (bus.tx_ready) begin
                    r_tx_valid   <= 1'b0;
                    r_meta_ready <= 1'b1;
                    r_phase      <= PH_IDLE;
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign bus.meta_ready  = r_meta_ready;
    assign bus.pl_accept   = r_pl_accept;
    assign bus.pl_drop     = r_pl_drop;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_flags    = r_tx_flags;
    assign bus.tx_seq_num  = r_tx_seq;
    assign bus.tx_ack_num  = r_tx_ack;
    assign bus.tx_src_port = r_tx_src;
    assign bus.tx_dst_port = r_tx_dst;
    assign bus.tx_window   = r_tx_window;
    assign conn_state      = r_conn_state;
    assign peer_window     = r_peer_window;

`ifdef TCP_CTRL_STATS_EN
    logic [15:0] r_stat_rx, r_stat_drops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rx    <= 16'd0;
            r_stat_drops <= 16'd0;
        end else begin
            if (w_meta_hs && (r_stat_rx != 16'hFFFF)) r_stat_rx <= r_stat_rx + 16'd1;
            if ((r_phase == PH_EVAL) && !w_accept && (r_stat_drops != 16'hFFFF))
                r_stat_drops <= r_stat_drops + 16'd1;
        end
    end

    assign stat_rx_segs = r_stat_rx;
    assign stat_drops   = r_stat_drops;
`else
    assign stat_rx_segs = 16'd0;
    assign stat_drops   = 16'd0;
`endif
endmodule
